// File: rtl/sar_avg_pkg.sv
// Shared types and width helpers for the SAR conversion sequencer / oversampling averager.
`timescale 1ns/1ps
package sar_avg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic int acc_width(input int data_w, input int max_osr_log2);
      return data_w + max_osr_log2;
   endfunction

   function automatic int osr_width(input int max_osr_log2);
      return $clog2(max_osr_log2 + 1);
   endfunction

endpackage

// File: rtl/sar_avg_hold.sv
// One-entry valid/ready holding register; a load accepted when empty or draining the same cycle.
// Latency 1 cycle load->out_vld; a load while full and not draining is dropped and sets sticky overrun.
`timescale 1ns/1ps
module sar_avg_hold #(
   parameter int W = 11
) (
   input  logic         f100m_clk,
   input  logic         rstb,
   input  logic         clr,
   input  logic         load_vld,
   input  logic [W-1:0] load_dat,
   output logic         out_vld,
   input  logic         out_rdy,
   output logic [W-1:0] out_dat,
   output logic         overrun
);

   logic accept;
   assign accept = !out_vld || out_rdy;

   always_ff @(posedge f100m_clk) begin
      if (!rstb) begin
         out_vld <= 1'b0;
         out_dat <= '0;
         overrun <= 1'b0;
      end else begin
         if (load_vld && accept) begin
            out_vld <= 1'b1;
            out_dat <= load_dat;
         end else if (out_vld && out_rdy) begin
            out_vld <= 1'b0;
         end
         // A drop in the same cycle as a clear still reports the lost window
         if (load_vld && !accept)
            overrun <= 1'b1;
         else if (clr)
            overrun <= 1'b0;
      end
   end

endmodule

// File: rtl/sar_avg_seq.sv
// SAR conversion sequencer + 2^osr oversampling averager; result 2 cycles after the window's last eoc.
// Output held in a one-entry buffer under avg_valid/avg_ready; windows finishing while it is full are dropped (overrun). Option: SAR_AVG_MINMAX_EN.
`timescale 1ns/1ps
module sar_avg_seq
   import sar_avg_pkg::*;
#(
   parameter int DATA_W       = 10,
   parameter int MAX_OSR_LOG2 = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic                              f100m_clk,
   input  logic                              rstb,
   input  logic                              enable,
   input  logic [$clog2(MAX_OSR_LOG2+1)-1:0] osr_log2,
   input  logic                              eoc,
   input  logic                              err,
   input  logic                              warn,
   input  logic [DATA_W-1:0]                 sar_code,
   output logic                              soc,
   output logic                              avg_valid,
   input  logic                              avg_ready,
   output logic [DATA_W-1:0]                 avg_data,
   output logic                              avg_warn,
   output logic                              overrun,
   output logic                              timeout
`ifdef SAR_AVG_MINMAX_EN
   ,
   output logic [DATA_W-1:0]                 avg_min,
   output logic [DATA_W-1:0]                 avg_max
`endif
);

   localparam int OSR_W = osr_width(MAX_OSR_LOG2);
   localparam int ACC_W = acc_width(DATA_W, MAX_OSR_LOG2);
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam int CNT_W = MAX_OSR_LOG2 + 1;
   localparam logic [OSR_W-1:0] OSR_MAX = OSR_W'(MAX_OSR_LOG2);
`ifdef SAR_AVG_MINMAX_EN
   localparam int HOLD_W = 3*DATA_W + 1;
`else
   localparam int HOLD_W = DATA_W + 1;
`endif

   state_t             state, state_nxt;
   logic [ACC_W-1:0]   acc;
   logic [CNT_W-1:0]   cnt;
   logic [TMO_W-1:0]   tmo_cnt;
   logic [OSR_W-1:0]   osr_eff;
   logic               win_warn;
   logic               hold_load;
   logic [HOLD_W-1:0]  hold_in, hold_out;

   logic [OSR_W-1:0]   osr_clamped;
   logic               smp_vld, win_full, tmo_hit, win_start;
   logic [CNT_W-1:0]   cnt_inc, cnt_tgt;
   logic [ACC_W-1:0]   acc_shr;

   assign osr_clamped = (osr_log2 > OSR_MAX) ? OSR_MAX : osr_log2;
   assign smp_vld     = eoc && !err;
   assign cnt_inc     = cnt + CNT_W'(1);
   assign cnt_tgt     = CNT_W'(1) << osr_eff;
   assign win_full    = smp_vld && (cnt_inc == cnt_tgt);
   assign tmo_hit     = (tmo_cnt == TMO_W'(TIMEOUT));
   assign win_start   = enable && (state == IDLE || state == DONE);
   assign acc_shr     = acc >> osr_eff;

   always_ff @(posedge f100m_clk) begin
      if (!rstb) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (enable) state_nxt = START;
         START: state_nxt = enable ? WAIT : IDLE;
         WAIT: begin
            if (!enable)     state_nxt = IDLE;
            else if (eoc)    state_nxt = win_full ? DONE : START;
            else if (tmo_hit) state_nxt = START;
         end
         DONE:  state_nxt = enable ? START : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      soc       = (state == START);
      hold_load = (state == DONE);
   end

   always_ff @(posedge f100m_clk) begin
      if (!rstb) begin
         acc      <= '0;
         cnt      <= '0;
         tmo_cnt  <= '0;
         osr_eff  <= '0;
         win_warn <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         if (warn && state != IDLE) win_warn <= 1'b1;
         if (win_start) begin
            acc      <= '0;
            cnt      <= '0;
            win_warn <= 1'b0;
            osr_eff  <= osr_clamped;
         end
         if (state == START) tmo_cnt <= '0;
         // eoc outranks the timeout; an err-tagged eoc only retries the slot
         if (state == WAIT && enable) begin
            if (smp_vld) begin
               acc <= acc + ACC_W'(sar_code);
               cnt <= cnt_inc;
            end else if (!eoc && tmo_hit) begin
               timeout <= 1'b1;
            end else if (!eoc) begin
               tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
         end
         if (!enable) timeout <= 1'b0;
      end
   end

`ifdef SAR_AVG_MINMAX_EN
   logic [DATA_W-1:0] win_min, win_max;

   always_ff @(posedge f100m_clk) begin
      if (!rstb) begin
         win_min <= '0;
         win_max <= '0;
      end else if (win_start) begin
         win_min <= '1;
         win_max <= '0;
      end else if (state == WAIT && enable && smp_vld) begin
         if (sar_code < win_min) win_min <= sar_code;
         if (sar_code > win_max) win_max <= sar_code;
      end
   end

   assign hold_in = {win_min, win_max, win_warn | warn, acc_shr[DATA_W-1:0]};
   assign {avg_min, avg_max, avg_warn, avg_data} = hold_out;
`else
   assign hold_in = {win_warn | warn, acc_shr[DATA_W-1:0]};
   assign {avg_warn, avg_data} = hold_out;
`endif

   sar_avg_hold #(.W(HOLD_W)) u_hold (
      .f100m_clk (f100m_clk),
      .rstb      (rstb),
      .clr       (!enable),
      .load_vld  (hold_load),
      .load_dat  (hold_in),
      .out_vld   (avg_valid),
      .out_rdy   (avg_ready),
      .out_dat   (hold_out),
      .overrun   (overrun)
   );

endmodule

// File: doc/sar_avg_seq.md
Name: sar_avg_seq

Overview:
- Conversion sequencer and oversampling averager placed directly downstream of the SAR digital controller's resynchronised eoc/err/warn pulses, in the f100m_clk domain.
- Issues single-cycle soc requests, collects 2^osr_log2 codes, and emits their truncated mean through a valid/ready output with a one-entry holding buffer.
- Conversions that end with err are excluded from the window. Missing eoc is caught by a timeout.

Parameters:
- DATA_W, 10, SAR code width.
- MAX_OSR_LOG2, 4, largest oversampling exponent; accumulator width is DATA_W+MAX_OSR_LOG2.
- TIMEOUT, 255, cycles to wait for eoc after soc before declaring a timeout; counter width is $clog2(TIMEOUT+1).

Ports:
- f100m_clk  in  1  clock.
- rstb  in  1  reset, synchronous, active-low.
- enable  in  1  continuous-conversion enable.
- osr_log2  in  $clog2(MAX_OSR_LOG2+1)  window size exponent; sampled at window start; values above MAX_OSR_LOG2 are clamped.
- eoc  in  1  single-cycle end-of-conversion pulse, already resynchronised.
- err  in  1  single-cycle conversion-error pulse, already resynchronised.
- warn  in  1  single-cycle warning pulse, already resynchronised.
- sar_code  in  DATA_W  conversion result; valid in the eoc cycle.
- soc  out  1  single-cycle start-of-conversion pulse.
- avg_valid  out  1  averaged result available.
- avg_ready  in  1  consumer accepts avg_data.
- avg_data  out  DATA_W  averaged code.
- avg_warn  out  1  at least one warn pulse occurred in the window; qualified by avg_valid.
- overrun  out  1  sticky; set when a completed window is dropped; cleared by reset or by enable=0.
- timeout  out  1  sticky; set on eoc timeout; cleared by reset or by enable=0.

Behaviour:
- Reset: every flop is cleared on a rising f100m_clk edge when rstb=0. All outputs are 0, the FSM is in IDLE, and acc, cnt and tmo_cnt are 0.
- FSM states and transitions:
  - IDLE: if enable=1, go to START; latch osr_eff=min(osr_log2, MAX_OSR_LOG2); clear acc, cnt and the window warn flag.
  - START: soc=1 for exactly this cycle; load tmo_cnt=0; go to WAIT.
  - WAIT: per-cycle priority is eoc > timeout > count.
    - eoc=1 with err=0 in the same cycle: acc += sar_code, zero-extended; cnt++.
    - eoc=1 with err=1: the sample is discarded and cnt is unchanged.
    - Either eoc case: if cnt reaches 2^osr_eff this cycle, go to DONE; otherwise go to START.
    - No eoc and tmo_cnt==TIMEOUT: set timeout, go to START (retry); acc is kept.
    - Otherwise tmo_cnt++.
  - DONE: result = acc >> osr_eff, truncated to DATA_W bits.
    - Holding buffer empty, or being emptied this cycle by avg_valid&avg_ready: load it and set avg_valid.
    - Holding buffer full and not draining: drop the result and set overrun.
    - Either case: if enable=1, restart the window (same actions as leaving IDLE) and go to START; else go to IDLE.
- err pulse outside an eoc cycle: ignored.
- warn pulse in any state other than IDLE: sets the window warn flag, which is copied to avg_warn with the data.
- enable=0 in START or WAIT: abort immediately to IDLE and discard the partial window. A conversion already in flight is not waited for; a later stray eoc in IDLE is ignored. The holding buffer keeps its content.
- Output handshake:
  - avg_valid, avg_data and avg_warn stay stable until the avg_valid&avg_ready cycle.
  - avg_valid drops the cycle after acceptance unless it is reloaded in that same cycle.
- Latency: the window's last eoc goes to DONE on the next edge; avg_valid rises one cycle later, i.e. two cycles after the last eoc. Back-to-back soc spacing is at least 2 cycles (START, then WAIT with an immediate eoc).
- Accumulator overflow cannot occur: (2^MAX_OSR_LOG2)·(2^DATA_W−1) fits in the accumulator width.

Optional Feature:
- Macro SAR_AVG_MINMAX_EN.
- When defined, adds outputs avg_min[DATA_W-1:0] and avg_max[DATA_W-1:0]:
  - Contain the min and max of the valid (err=0) codes in the window.
  - Captured into the holding buffer with avg_data, under the same handshake.
  - Reset value 0; the window trackers initialise to max=0 and min=all-ones.
- When undefined, these ports and their logic do not exist; everything else is identical.

Decomposition:
- Package sar_avg_pkg holds:
  - the FSM state typedef (IDLE, START, WAIT, DONE);
  - localparam helpers for accumulator width and osr width.
- One natural sub-module: sar_avg_hold, the one-entry valid/ready holding register with an overrun output; reusable for other ADC result paths.

Test Plan:
- Basic window: osr_log2=2, codes 100, 101, 102, 103, each eoc 20 cycles after soc -> avg_data=101, avg_valid rises 2 cycles after the 4th eoc, exactly 4 soc pulses before avg_valid.
- Error exclusion: osr_log2=1, codes 200(err), 300, 500 -> avg_data=400, three soc pulses issued.
- Timeout: TIMEOUT=255, no eoc after soc -> timeout=1 at cycle 256 after soc, a new soc follows the next cycle; the window completes normally afterwards.
- Overrun and backpressure: osr_log2=0, avg_ready=0, two conversions (codes 10, 20) -> avg_data holds 10, overrun=1; raise avg_ready -> one transfer of 10.
- Abort: enable dropped mid-window (osr_log2=3, 5 samples in) -> no avg_valid; re-enable -> fresh 8-sample window, and a stray eoc while in IDLE has no effect.
- Reset mid-operation: rstb=0 for one edge in WAIT with avg_valid=1 -> all outputs 0 on the next edge, FSM in IDLE; with SAR_AVG_MINMAX_EN, codes 5, 9, 7, 3 -> avg_min=3, avg_max=9.
